// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: core redirect, instruction memory port and decoded-stage handshake.
// The master side is the fetch unit; the slave side is the memory plus core environment.
`timescale 1ns/1ps

interface instr_fetch_unit_if #(
    parameter int n = 32
);
    logic         Redirect;
    logic [n-1:0] RedirectPC;
    logic         MemReq;
    logic [n-1:0] MemAddr;
    logic         MemAck;
    logic [n-1:0] MemData;
    logic         InstrValid;
    logic [n-1:0] Instr;
    logic [n-1:0] InstrPC;
    logic         InstrReady;

    modport master (
        input  Redirect, RedirectPC, MemAck, MemData, InstrReady,
        output MemReq, MemAddr, InstrValid, Instr, InstrPC
    );

    modport slave (
        output Redirect, RedirectPC, MemAck, MemData, InstrReady,
        input  MemReq, MemAddr, InstrValid, Instr, InstrPC
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, feeding a 2-entry
// {PC, instruction} FIFO whose head lives in the registered output stage.
`timescale 1ns/1ps

module instr_fetch_unit #(
    parameter int           n        = 32,
    parameter logic [n-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    instr_fetch_unit_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [n-1:0] fetch_pc_q, fetch_pc_d;
    logic         mem_req_q, mem_req_d;
    logic [n-1:0] mem_addr_q, mem_addr_d;

    // FIFO head doubles as the registered output stage; skid holds the second entry.
    logic         valid_q;
    logic [n-1:0] instr_q, instr_pc_q;
    logic [n-1:0] skid_instr_q, skid_pc_q;
    logic [1:0]   count_q;

    logic [n-1:0] redirect_pc;
    logic         push, pop;

    assign redirect_pc = {bus.RedirectPC[n-1:2], 2'b00};
    assign pop         = valid_q & bus.InstrReady;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // NOTE: every always_comb output is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A redirect flushes the FIFO, so the target can be requested at once.
                if (bus.Redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = redirect_pc;
                end else if (count_q < 2'd2) begin
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (bus.MemAck) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (bus.Redirect) begin
                        fetch_pc_d = redirect_pc;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + n'(4);
                    end
                end else if (bus.Redirect) begin
                    state_d    = DRAIN;
                    fetch_pc_d = redirect_pc;
                end
            end
            DRAIN: begin
                // The stale request stays on the bus until memory answers it.
                if (bus.Redirect) fetch_pc_d = redirect_pc;
                if (bus.MemAck) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q    <= 2'd0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else if (bus.Redirect) begin
            // Flush wins over any same-cycle pop; Instr/InstrPC keep their last values.
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    count_q <= count_q + 2'd1;
                    if (count_q == 2'd0) begin
                        valid_q    <= 1'b1;
                        instr_q    <= bus.MemData;
                        instr_pc_q <= mem_addr_q;
                    end
                end
                2'b01: begin
                    count_q <= count_q - 2'd1;
                    if (count_q == 2'd2) begin
                        instr_q    <= skid_instr_q;
                        instr_pc_q <= skid_pc_q;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        instr_q    <= skid_instr_q;
                        instr_pc_q <= skid_pc_q;
                    end else begin
                        instr_q    <= bus.MemData;
                        instr_pc_q <= mem_addr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the skid entry is storage qualified by count_q, so it needs no reset.
    always_ff @(posedge Clk) begin
        if (push && (count_q != 2'd0) && !(pop && count_q == 2'd1)) begin
            skid_instr_q <= bus.MemData;
            skid_pc_q    <= mem_addr_q;
        end
    end

    assign bus.MemReq     = mem_req_q;
    assign bus.MemAddr    = mem_addr_q;
    assign bus.InstrValid = valid_q;
    assign bus.Instr      = instr_q;
    assign bus.InstrPC    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch sequencing, backpressure, redirects, reset
// and PC wrap-around, with a second instance built at RESET_PC = FFFF_FFFC.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

    logic Clk = 1'b0;
    logic Reset;
    logic Reset2;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    instr_fetch_unit_if #(.n(32)) bus  ();
    instr_fetch_unit_if #(.n(32)) bus2 ();

    instr_fetch_unit #(.n(32), .RESET_PC(32'h0000_0000)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.master)
    );

    instr_fetch_unit #(.n(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .Clk   (Clk),
        .Reset (Reset2),
        .bus   (bus2.master)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset              = 1'b0;
        bus.Redirect       = 1'b0;
        bus.RedirectPC     = '0;
        bus.MemAck         = 1'b0;
        bus.MemData        = '0;
        bus.InstrReady     = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && bus.MemReq !== 1'b1; i++) tick();
        checks++;
        if (bus.MemReq !== 1'b1) begin
            errors++;
            $display("FAIL wait_req: MemReq=%b after 20 cycles, expected 1", bus.MemReq);
        end
    endtask

    // Waits for a request, holds it for 'hold' cycles while checking stability, then acks.
    task automatic serve(input int hold, output logic [31:0] addr);
        wait_req();
        addr = bus.MemAddr;
        repeat (hold) tick();
        checks++;
        if (bus.MemReq !== 1'b1 || bus.MemAddr !== addr) begin
            errors++;
            $display("FAIL req_stable: MemReq=%b MemAddr=%h, expected 1 %h", bus.MemReq, bus.MemAddr, addr);
        end
        bus.MemAck  = 1'b1;
        bus.MemData = word(addr);
        tick();
        bus.MemAck  = 1'b0;
        bus.MemData = '0;
    endtask

    task automatic test_reset();
        do_reset();
        Reset = 1'b0;
        tick();
        checks++; if (bus.MemReq !== 1'b0) begin errors++; $display("FAIL reset_memreq: got %b expected 0", bus.MemReq); end
        checks++; if (bus.MemAddr !== 32'h0) begin errors++; $display("FAIL reset_memaddr: got %h expected 0", bus.MemAddr); end
        checks++; if (bus.InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.InstrValid); end
        checks++; if (bus.Instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.Instr); end
        checks++; if (bus.InstrPC !== 32'h0) begin errors++; $display("FAIL reset_instrpc: got %h expected 0", bus.InstrPC); end
        Reset = 1'b1;
        tick();
        checks++;
        if (bus.MemReq !== 1'b1 || bus.MemAddr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: MemReq=%b MemAddr=%h, expected 1 00000000", bus.MemReq, bus.MemAddr);
        end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] a;
        logic [31:0] exp;
        do_reset();
        bus.InstrReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 32'(i * 4);
            serve(2, a);
            checks++; if (a !== exp) begin errors++; $display("FAIL basic_addr: got %h expected %h", a, exp); end
            checks++;
            if (bus.InstrValid !== 1'b1 || bus.InstrPC !== exp || bus.Instr !== word(exp)) begin
                errors++;
                $display("FAIL basic_instr: valid=%b pc=%h instr=%h, expected 1 %h %h",
                         bus.InstrValid, bus.InstrPC, bus.Instr, exp, word(exp));
            end
            checks++; if (bus.MemReq !== 1'b0) begin errors++; $display("FAIL basic_idle_gap: MemReq=%b expected 0", bus.MemReq); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        do_reset();
        bus.InstrReady = 1'b0;
        serve(1, a);
        serve(1, a);
        checks++;
        if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h0) begin
            errors++;
            $display("FAIL bp_head: valid=%b pc=%h, expected 1 00000000", bus.InstrValid, bus.InstrPC);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.MemReq !== 1'b0) begin errors++; $display("FAIL bp_full_noreq: MemReq=%b expected 0", bus.MemReq); end
        end
        bus.InstrReady = 1'b1;
        tick();
        checks++;
        if (bus.InstrPC !== 32'h4 || bus.Instr !== word(32'h4)) begin
            errors++;
            $display("FAIL bp_order: pc=%h instr=%h, expected 00000004 %h", bus.InstrPC, bus.Instr, word(32'h4));
        end
        serve(1, a);
        checks++; if (a !== 32'h8) begin errors++; $display("FAIL bp_next_addr: got %h expected 00000008", a); end
    endtask

    task automatic test_push_pop();
        logic [31:0] a;
        do_reset();
        bus.InstrReady = 1'b0;
        serve(1, a);
        wait_req();
        tick();
        bus.MemAck     = 1'b1;
        bus.MemData    = word(32'h4);
        bus.InstrReady = 1'b1;
        tick();
        bus.MemAck     = 1'b0;
        bus.InstrReady = 1'b0;
        checks++;
        if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h4 || bus.Instr !== word(32'h4)) begin
            errors++;
            $display("FAIL pushpop_head: valid=%b pc=%h instr=%h, expected 1 00000004 %h",
                     bus.InstrValid, bus.InstrPC, bus.Instr, word(32'h4));
        end
        serve(1, a);
        checks++; if (bus.InstrPC !== 32'h4) begin errors++; $display("FAIL pushpop_keep: pc=%h expected 00000004", bus.InstrPC); end
        bus.InstrReady = 1'b1;
        tick();
        checks++;
        if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h8) begin
            errors++;
            $display("FAIL pushpop_second: valid=%b pc=%h, expected 1 00000008", bus.InstrValid, bus.InstrPC);
        end
        tick();
        checks++; if (bus.InstrValid !== 1'b0) begin errors++; $display("FAIL pushpop_empty: valid=%b expected 0", bus.InstrValid); end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] a;
        do_reset();
        bus.InstrReady = 1'b1;
        wait_req();
        tick();
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h0000_0103;
        tick();
        bus.Redirect   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.MemReq !== 1'b1 || bus.MemAddr !== 32'h0) begin
                errors++;
                $display("FAIL drain_hold: MemReq=%b MemAddr=%h, expected 1 00000000", bus.MemReq, bus.MemAddr);
            end
            if (i == 0) tick();
        end
        bus.MemAck  = 1'b1;
        bus.MemData = word(32'h0);
        tick();
        bus.MemAck  = 1'b0;
        checks++;
        if (bus.InstrValid !== 1'b0 || bus.MemReq !== 1'b0) begin
            errors++;
            $display("FAIL drain_drop: valid=%b MemReq=%b, expected 0 0", bus.InstrValid, bus.MemReq);
        end
        serve(2, a);
        checks++; if (a !== 32'h100) begin errors++; $display("FAIL redirect_addr: got %h expected 00000100", a); end
        checks++;
        if (bus.InstrPC !== 32'h100 || bus.Instr !== word(32'h100)) begin
            errors++;
            $display("FAIL redirect_instr: pc=%h instr=%h, expected 00000100 %h", bus.InstrPC, bus.Instr, word(32'h100));
        end
    endtask

    task automatic test_redirect_drain();
        logic [31:0] a;
        do_reset();
        bus.InstrReady = 1'b1;
        wait_req();
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h0000_0200;
        tick();
        bus.RedirectPC = 32'h0000_03F2;
        tick();
        bus.Redirect   = 1'b0;
        checks++; if (bus.MemAddr !== 32'h0) begin errors++; $display("FAIL drain_redirect_hold: MemAddr=%h expected 00000000", bus.MemAddr); end
        bus.MemAck = 1'b1;
        tick();
        bus.MemAck = 1'b0;
        serve(1, a);
        checks++; if (a !== 32'h3F0) begin errors++; $display("FAIL drain_redirect_addr: got %h expected 000003f0", a); end
    endtask

    task automatic test_redirect_idle();
        logic [31:0] a;
        do_reset();
        bus.InstrReady = 1'b1;
        serve(2, a);
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h0000_0047;
        tick();
        bus.Redirect   = 1'b0;
        checks++;
        if (bus.InstrValid !== 1'b0 || bus.InstrPC !== 32'h0 || bus.Instr !== word(32'h0)) begin
            errors++;
            $display("FAIL redirect_pop_flush: valid=%b pc=%h instr=%h, expected 0 00000000 %h",
                     bus.InstrValid, bus.InstrPC, bus.Instr, word(32'h0));
        end
        checks++;
        if (bus.MemReq !== 1'b1 || bus.MemAddr !== 32'h44) begin
            errors++;
            $display("FAIL redirect_idle_req: MemReq=%b MemAddr=%h, expected 1 00000044", bus.MemReq, bus.MemAddr);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] a;
        do_reset();
        bus.InstrReady = 1'b0;
        serve(1, a);
        wait_req();
        tick();
        bus.MemAck     = 1'b1;
        bus.MemData    = word(32'h4);
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h0000_0200;
        bus.InstrReady = 1'b1;
        tick();
        bus.MemAck     = 1'b0;
        bus.Redirect   = 1'b0;
        bus.InstrReady = 1'b0;
        checks++;
        if (bus.InstrValid !== 1'b0 || bus.MemReq !== 1'b0) begin
            errors++;
            $display("FAIL simul_flush: valid=%b MemReq=%b, expected 0 0", bus.InstrValid, bus.MemReq);
        end
        serve(1, a);
        checks++; if (a !== 32'h200) begin errors++; $display("FAIL simul_addr: got %h expected 00000200", a); end
        checks++; if (bus.InstrPC !== 32'h200) begin errors++; $display("FAIL simul_instrpc: got %h expected 00000200", bus.InstrPC); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] a;
        do_reset();
        bus.InstrReady = 1'b0;
        serve(1, a);
        wait_req();
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (bus.MemReq !== 1'b0 || bus.MemAddr !== 32'h0 || bus.InstrValid !== 1'b0 ||
            bus.Instr !== 32'h0 || bus.InstrPC !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: req=%b addr=%h valid=%b instr=%h pc=%h, expected all 0",
                     bus.MemReq, bus.MemAddr, bus.InstrValid, bus.Instr, bus.InstrPC);
        end
        bus.MemAck  = 1'b1;
        bus.MemData = word(32'h4);
        tick();
        Reset = 1'b1;
        tick();
        bus.MemAck = 1'b0;
        checks++;
        if (bus.InstrValid !== 1'b0 || bus.MemReq !== 1'b1 || bus.MemAddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_restart: valid=%b MemReq=%b MemAddr=%h, expected 0 1 00000000",
                     bus.InstrValid, bus.MemReq, bus.MemAddr);
        end
    endtask

    task automatic test_wrap();
        Reset2 = 1'b1;
        tick();
        checks++;
        if (bus2.MemReq !== 1'b1 || bus2.MemAddr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_first: MemReq=%b MemAddr=%h, expected 1 fffffffc", bus2.MemReq, bus2.MemAddr);
        end
        bus2.MemAck  = 1'b1;
        bus2.MemData = word(32'hFFFF_FFFC);
        tick();
        bus2.MemAck  = 1'b0;
        checks++;
        if (bus2.InstrValid !== 1'b1 || bus2.InstrPC !== 32'hFFFF_FFFC || bus2.Instr !== word(32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL wrap_instr: valid=%b pc=%h instr=%h, expected 1 fffffffc %h",
                     bus2.InstrValid, bus2.InstrPC, bus2.Instr, word(32'hFFFF_FFFC));
        end
        tick();
        checks++;
        if (bus2.MemReq !== 1'b1 || bus2.MemAddr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_second: MemReq=%b MemAddr=%h, expected 1 00000000", bus2.MemReq, bus2.MemAddr);
        end
    endtask

    initial begin
        Reset2           = 1'b0;
        bus2.Redirect    = 1'b0;
        bus2.RedirectPC  = '0;
        bus2.MemAck      = 1'b0;
        bus2.MemData     = '0;
        bus2.InstrReady  = 1'b1;

        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_push_pop();
        test_redirect_wait();
        test_redirect_drain();
        test_redirect_idle();
        test_simultaneous();
        test_reset_mid_wait();
        test_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the width of addresses and instruction words.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Redirect, input, 1 bit: the core took a branch or jump this cycle.
REQ-006 The block SHALL have port RedirectPC, input, n bits: the target PC, valid while Redirect=1.
REQ-007 The block SHALL have port MemReq, output, 1 bit: an instruction memory read request.
REQ-008 The block SHALL have port MemAddr, output, n bits: the word address of the request, bits [1:0] always 00.
REQ-009 The block SHALL have port MemAck, input, 1 bit: a one-cycle pulse meaning MemData holds the requested word.
REQ-010 The block SHALL have port MemData, input, n bits: the instruction word returned by memory.
REQ-011 The block SHALL have port InstrValid, output, 1 bit: Instr and InstrPC hold a fetched instruction.
REQ-012 The block SHALL have port Instr, output, n bits: the instruction word at the head of the buffer.
REQ-013 The block SHALL have port InstrPC, output, n bits: the address of Instr.
REQ-014 The block SHALL have port InstrReady, input, 1 bit: the core consumes the head entry when InstrValid=1 and InstrReady=1.

Function
REQ-015 The block SHALL hold a fetch PC register and a 2-entry FIFO of {PC, instruction} pairs, with registered outputs driven from the FIFO head.
REQ-016 The block SHALL implement the FSM states IDLE (no request), WAIT (request outstanding) and DRAIN (stale request outstanding after a redirect).
REQ-017 In IDLE, when FIFO occupancy is less than 2, the block SHALL go to WAIT and assert MemReq with MemAddr equal to the fetch PC on the next edge; at most one request SHALL be outstanding.
REQ-018 Once MemReq is asserted, MemReq and MemAddr SHALL stay stable until the cycle MemAck=1.
REQ-019 In WAIT with MemAck=1 and no Redirect, the block SHALL push {MemAddr, MemData}, advance the fetch PC by 4 (wrapping modulo 2^n, so FFFF_FFFC becomes 0000_0000), and return to IDLE.
REQ-020 Latency: a MemAck in cycle t SHALL give InstrValid=1 in cycle t+1 when the FIFO was empty; back-to-back requests SHALL be issued with one IDLE cycle between an ack and the next MemReq.
REQ-021 On Redirect=1, the block SHALL flush the FIFO (InstrValid=0 on the next cycle) and load the fetch PC with {RedirectPC[n-1:2], 2'b00}.
REQ-022 On Redirect=1 in WAIT without MemAck, the block SHALL enter DRAIN; in DRAIN it SHALL hold MemReq and the old MemAddr, discard the returned data at MemAck, and then go to IDLE.
REQ-023 When Redirect=1 and MemAck=1 in the same cycle, the block SHALL discard the data and go to IDLE.
REQ-024 A Redirect during DRAIN SHALL only update the fetch PC.
REQ-025 When Redirect=1 and a pop occur in the same cycle, the redirect SHALL take priority and the FIFO SHALL be empty afterwards.
REQ-026 A push and a pop in the same cycle SHALL leave the occupancy unchanged, with order preserved.
REQ-027 When the FIFO is full (2 entries), MemReq SHALL stay 0 until a pop occurs.
REQ-028 When InstrValid=0, Instr and InstrPC SHALL hold their last values; a pop SHALL be ignored if InstrValid=0.

Reset
REQ-029 When Reset=0, the block SHALL asynchronously force FSM=IDLE, fetch PC=RESET_PC, FIFO empty, MemReq=0, MemAddr=0, InstrValid=0, Instr=0 and InstrPC=0.
REQ-030 Reset asserted mid-request SHALL abandon the request; a MemAck arriving after reset SHALL be ignored while in IDLE.
REQ-031 After Reset goes high, MemReq SHALL first assert on the first rising edge.

Verification
REQ-032 Basic fetch: release reset, MemAck 2 cycles after each MemReq, InstrReady=1 -> MemAddr sequence 0,4,8,C; InstrPC and Instr match the returned memory words in order.
REQ-033 Backpressure: hold InstrReady=0 -> exactly 2 entries fetched, MemReq stays 0; set InstrReady=1 -> the next request is to address 8.
REQ-034 Redirect while WAIT: Redirect=1 with RedirectPC=0x0000_0103 -> MemReq held at the old address until ack, that data is dropped, the next MemAddr is 0x0000_0100.
REQ-035 Simultaneous events: Redirect, MemAck and InstrReady all =1 in the same cycle -> InstrValid=0 next cycle, the next MemAddr is the redirect target.
REQ-036 Wrap-around: RESET_PC=FFFF_FFFC -> MemAddr sequence FFFF_FFFC, 0000_0000.
REQ-037 Reset mid-WAIT: assert Reset=0 during an outstanding request -> all outputs 0 immediately; after release the first MemAddr is RESET_PC.
